apod_sum: RTL and testbench

- Downstream stage of the per-channel sample delay lines in the beamformer.
- Takes one delayed sample per channel each valid cycle and multiplies each by a programmable apodization weight.
- Sums all weighted channels through a pipelined adder tree and emits one beamformed sample.
- Counts samples along the scan line and flags the last sample of each line.

---
 rtl/apod_sum_pkg.sv | 25 ++
 rtl/apod_sum_if.sv | 32 +++
 rtl/apod_adder_tree.sv | 80 ++++++++
 rtl/apod_sum.sv | 114 +++++++++++
 tb/tb_apod_sum.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/apod_sum_pkg.sv
// apod_sum_pkg
//   Shared defaults and helpers for the apodization / beam-sum stage.
//   - DEF_* : default channel count, sample width, weight width, line length
//   - unity_weight() / UNITY_WEIGHT : weight value meaning x1.0 in Q1.(W-1)
//   - out_width() : full-precision output width of the weighted sum
package apod_sum_pkg;

    localparam int DEF_NUM_CH           = 8;
    localparam int DEF_DATA_WIDTH       = 16;
    localparam int DEF_WEIGHT_WIDTH     = 8;
    localparam int DEF_SAMPLES_PER_LINE = 1024;

    function automatic int unity_weight(input int weight_width);
        return 1 << (weight_width - 1);
    endfunction

    localparam int UNITY_WEIGHT = unity_weight(DEF_WEIGHT_WIDTH);

    // product width plus one growth bit per adder-tree level
    function automatic int out_width(input int num_ch, input int data_width,
                                     input int weight_width);
        return data_width + weight_width + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/apod_sum_if.sv
// apod_sum_if
//   Bundles the sample stream, weight write port and beamformed output.
//   master : drives din/din_valid/line_start and weight writes, receives dout*
//   slave  : the apod_sum block itself
interface apod_sum_if #(
    parameter int NUM_CH       = apod_sum_pkg::DEF_NUM_CH,
    parameter int DATA_WIDTH   = apod_sum_pkg::DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = apod_sum_pkg::DEF_WEIGHT_WIDTH,
    parameter int OUT_WIDTH    = apod_sum_pkg::out_width(NUM_CH, DATA_WIDTH, WEIGHT_WIDTH)
);

    logic [NUM_CH*DATA_WIDTH-1:0]   din;
    logic                           din_valid;
    logic                           line_start;
    logic                           w_wr_en;
    logic [$clog2(NUM_CH)-1:0]      w_wr_addr;
    logic [WEIGHT_WIDTH-1:0]        w_wr_data;
    logic signed [OUT_WIDTH-1:0]    dout;
    logic                           dout_valid;
    logic                           dout_last;

    modport master (
        output din, din_valid, line_start, w_wr_en, w_wr_addr, w_wr_data,
        input  dout, dout_valid, dout_last
    );

    modport slave (
        input  din, din_valid, line_start, w_wr_en, w_wr_addr, w_wr_data,
        output dout, dout_valid, dout_last
    );

endinterface

// File: rtl/apod_adder_tree.sv
// apod_adder_tree
//   Pipelined signed adder tree, one register level per pairwise add.
//   Each level widens by one bit so the sum never overflows.
//   Ports:
//     clk, reset (async, active-low)
//     in_valid/in_last/in_data : NUM_IN packed signed words of IN_WIDTH
//     out_valid/out_last/out_data : sum, IN_WIDTH+log2(NUM_IN) bits,
//                                   $clog2(NUM_IN) cycles after the input
//   Data registers load only on valid, so out_data holds between samples.
module apod_adder_tree #(
    parameter int NUM_IN   = 8,
    parameter int IN_WIDTH = 24,
    localparam int LEVELS  = $clog2(NUM_IN)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [NUM_IN*IN_WIDTH-1:0]    in_data,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [IN_WIDTH+LEVELS-1:0]    out_data
);

    for (genvar l = 1; l <= LEVELS; l++) begin : lvl_g
        localparam int N = NUM_IN >> l;
        localparam int W = IN_WIDTH + l;

        logic [2*N*(W-1)-1:0] prev_data;
        logic                 prev_valid;
        logic                 prev_last;
        logic [N*W-1:0]       sum_d;
        logic [N*W-1:0]       sum_q;
        logic                 valid_d;
        logic                 valid_q;
        logic                 last_d;
        logic                 last_q;

        if (l == 1) begin : g_src
            assign prev_data  = in_data;
            assign prev_valid = in_valid;
            assign prev_last  = in_last;
        end else begin : g_src
            assign prev_data  = lvl_g[l-1].sum_q;
            assign prev_valid = lvl_g[l-1].valid_q;
            assign prev_last  = lvl_g[l-1].last_q;
        end

        always_comb begin
            sum_d   = sum_q;
            valid_d = prev_valid;
            last_d  = prev_valid & prev_last;
            if (prev_valid) begin
                for (int j = 0; j < N; j++) begin
                    // explicit sign extension by one bit before the add
                    sum_d[j*W +: W] =
                        {prev_data[(2*j+1)*(W-1)-1], prev_data[2*j*(W-1) +: W-1]} +
                        {prev_data[(2*j+2)*(W-1)-1], prev_data[(2*j+1)*(W-1) +: W-1]};
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sum_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                valid_q <= valid_d;
                last_q  <= last_d;
            end
        end
    end

    assign out_data  = lvl_g[LEVELS].sum_q;
    assign out_valid = lvl_g[LEVELS].valid_q;
    assign out_last  = lvl_g[LEVELS].last_q;

endmodule

// File: rtl/apod_sum.sv
// apod_sum
//   Apodization and channel sum for the beamformer. Each valid cycle every
//   channel sample is multiplied by its weight (Q1.(WEIGHT_WIDTH-1),
//   unsigned), then all products are summed in a pipelined adder tree.
//   Ports:
//     clk, reset (async, active-low)
//     bus (apod_sum_if.slave): din/din_valid/line_start, weight write port,
//                              dout/dout_valid/dout_last
//   Latency din_valid -> dout_valid is 1 + log2(NUM_CH) cycles.
//   dout_last marks sample SAMPLES_PER_LINE-1 of each scan line.
module apod_sum import apod_sum_pkg::*; #(
    parameter int NUM_CH           = DEF_NUM_CH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH     = DEF_WEIGHT_WIDTH,
    parameter int SAMPLES_PER_LINE = DEF_SAMPLES_PER_LINE,
    parameter int OUT_WIDTH        = out_width(NUM_CH, DATA_WIDTH, WEIGHT_WIDTH)
) (
    input  logic        clk,
    input  logic        reset,
    apod_sum_if.slave   bus
);

    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int CW = $clog2(SAMPLES_PER_LINE);
    localparam logic [WEIGHT_WIDTH-1:0] W_UNITY = WEIGHT_WIDTH'(unity_weight(WEIGHT_WIDTH));

    logic [WEIGHT_WIDTH-1:0] weight_d [NUM_CH];
    logic [WEIGHT_WIDTH-1:0] weight_q [NUM_CH];

    logic [NUM_CH*PW-1:0]    prod_d;
    logic [NUM_CH*PW-1:0]    prod_q;
    logic                    valid0_d;
    logic                    valid0_q;
    logic                    last0_d;
    logic                    last0_q;

    logic [CW-1:0]           cnt_d;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_base;
    logic                    at_last;

    // The multiplier reads weight_q, so a sample accepted in the same cycle
    // as a write still sees the old weight.
    always_comb begin
        weight_d = weight_q;
        if (bus.w_wr_en) begin
            weight_d[bus.w_wr_addr] = bus.w_wr_data;
        end
    end

    always_comb begin
        prod_d   = prod_q;
        valid0_d = bus.din_valid;
        if (bus.din_valid) begin
            for (int k = 0; k < NUM_CH; k++) begin
                prod_d[k*PW +: PW] =
                    PW'($signed(bus.din[k*DATA_WIDTH +: DATA_WIDTH])) *
                    PW'($signed({1'b0, weight_q[k]}));
            end
        end
    end

    // line_start rebases the count to 0 before this cycle's sample is indexed
    always_comb begin
        cnt_base = bus.line_start ? '0 : cnt_q;
        at_last  = (cnt_base == CW'(SAMPLES_PER_LINE - 1));
        cnt_d    = cnt_base;
        if (bus.din_valid) begin
            cnt_d = at_last ? '0 : cnt_base + CW'(1);
        end
        last0_d  = bus.din_valid & at_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                weight_q[k] <= W_UNITY;
            end
            prod_q   <= '0;
            valid0_q <= 1'b0;
            last0_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            weight_q <= weight_d;
            prod_q   <= prod_d;
            valid0_q <= valid0_d;
            last0_q  <= last0_d;
            cnt_q    <= cnt_d;
        end
    end

    logic [OUT_WIDTH-1:0] tree_data;
    logic                 tree_valid;
    logic                 tree_last;

    apod_adder_tree #(
        .NUM_IN   (NUM_CH),
        .IN_WIDTH (PW)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (valid0_q),
        .in_last   (last0_q),
        .in_data   (prod_q),
        .out_valid (tree_valid),
        .out_last  (tree_last),
        .out_data  (tree_data)
    );

    assign bus.dout       = tree_data;
    assign bus.dout_valid = tree_valid;
    assign bus.dout_last  = tree_last;

endmodule

// File: tb/tb_apod_sum.sv
// tb_apod_sum
//   Directed bench for apod_sum: 8 channels, 16-bit samples, 8-bit weights,
//   4 samples per line. Inputs change and outputs are sampled on the falling
//   edge; expected values are hand-computed constants.
module tb_apod_sum;

    localparam int NC  = 8;
    localparam int DW  = 16;
    localparam int WW  = 8;
    localparam int SPL = 4;
    localparam int OW  = 27;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   j;

    int pat_v [5] = '{1, 0, 1, 1, 0};
    int pat_x [5] = '{1, 0, 2, 3, 0};
    int pat_d [5] = '{1024, 1024, 2048, 3072, 3072};
    int pat_l [5] = '{0, 0, 0, 1, 0};

    apod_sum_if #(
        .NUM_CH(NC), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .OUT_WIDTH(OW)
    ) bus ();

    apod_sum #(
        .NUM_CH(NC), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
        .SAMPLES_PER_LINE(SPL), .OUT_WIDTH(OW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.din_valid  = 1'b0;
        bus.line_start = 1'b0;
        bus.w_wr_en    = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < NC; k++) bus.din[k*DW +: DW] = DW'(v);
    endtask

    task automatic wr(input int a, input int d);
        bus.w_wr_en   = 1'b1;
        bus.w_wr_addr = 3'(a);
        bus.w_wr_data = 8'(d);
    endtask

    initial begin
        reset         = 1'b0;
        bus.din       = '0;
        bus.w_wr_addr = '0;
        bus.w_wr_data = '0;
        idle();

        // reset state
        repeat (3) tick();
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_dout", bus.dout, 0);
        tick();
        reset = 1'b1;

        // unity weights, all channels 100 -> 8*100*128
        tick(); set_all(100); bus.din_valid = 1'b1;
        tick(); idle(); chk("lat_c1", bus.dout_valid, 0);
        tick(); chk("lat_c2", bus.dout_valid, 0);
        tick(); chk("lat_c3", bus.dout_valid, 0);
        tick(); chk("lat_c4_valid", bus.dout_valid, 1);
        chk("lat_c4_dout", bus.dout, 102400);
        tick(); chk("lat_c5_valid", bus.dout_valid, 0);
        chk("lat_c5_hold", bus.dout, 102400);

        // weight write before sample, then same-cycle write with sample
        tick(); wr(3, 0);
        tick(); bus.w_wr_en = 1'b0; set_all(0); bus.din[3*DW +: DW] = 16'sd1000;
        bus.din_valid = 1'b1;
        tick(); idle(); wr(3, 128);
        tick(); wr(3, 0); bus.din_valid = 1'b1;
        tick(); bus.w_wr_en = 1'b0; bus.din_valid = 1'b1;
        tick(); idle();
        chk("w0_valid", bus.dout_valid, 1);
        chk("w0_dout", bus.dout, 0);
        tick(); chk("w_gap_valid", bus.dout_valid, 0);
        tick(); chk("w_same_valid", bus.dout_valid, 1);
        chk("w_same_dout", bus.dout, 128000);
        tick(); chk("w_next_valid", bus.dout_valid, 1);
        chk("w_next_dout", bus.dout, 0);

        // full-scale negative: 8 * -32768 * 255
        for (int k = 0; k < NC; k++) begin
            tick(); idle(); wr(k, 255);
        end
        tick(); bus.w_wr_en = 1'b0; set_all(-32768); bus.din_valid = 1'b1;
        tick(); idle();
        repeat (3) tick();
        chk("max_valid", bus.dout_valid, 1);
        chk("max_dout", bus.dout, -66846720);

        // 10 back-to-back samples, line_start on the first
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i >= 4) begin
                j = i - 4;
                chk("line1_valid", bus.dout_valid, (j < 10) ? 1 : 0);
                if (j < 10) begin
                    chk("line1_last", bus.dout_last, (j == 3 || j == 7) ? 1 : 0);
                    chk("line1_dout", bus.dout, 255 * (j + 1));
                end
            end
            idle();
            if (i < 10) begin
                set_all(0);
                bus.din[0 +: DW] = DW'(i + 1);
                bus.din_valid    = 1'b1;
                bus.line_start   = (i == 0);
            end
        end

        // line_start again with the sixth sample
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i >= 4) begin
                j = i - 4;
                chk("line2_valid", bus.dout_valid, (j < 10) ? 1 : 0);
                if (j < 10) begin
                    chk("line2_last", bus.dout_last, (j == 3 || j == 8) ? 1 : 0);
                end
            end
            idle();
            if (i < 10) begin
                set_all(1);
                bus.din_valid  = 1'b1;
                bus.line_start = (i == 0 || i == 5);
            end
        end

        // reset with samples in flight
        tick(); set_all(1); bus.din_valid = 1'b1;
        tick();
        tick();
        tick(); idle();
        tick();
        chk("pre_rst_valid", bus.dout_valid, 1);
        chk("pre_rst_dout", bus.dout, 2040);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", bus.dout_valid, 0);
        chk("async_rst_dout", bus.dout, 0);
        chk("async_rst_last", bus.dout_last, 0);
        tick();
        tick(); reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_quiet", bus.dout_valid, 0);
        end
        tick(); set_all(100); bus.din_valid = 1'b1;
        tick(); idle();
        repeat (3) tick();
        chk("post_rst_valid", bus.dout_valid, 1);
        chk("post_rst_unity", bus.dout, 102400);
        chk("post_rst_last", bus.dout_last, 0);

        // valid pattern 1,0,1,1,0 with holds in the gaps
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i >= 4) begin
                j = i - 4;
                chk("pat_valid", bus.dout_valid, pat_v[j]);
                chk("pat_dout", bus.dout, pat_d[j]);
                chk("pat_last", bus.dout_last, pat_l[j]);
            end
            idle();
            if (i < 5 && pat_v[i] == 1) begin
                set_all(pat_x[i]);
                bus.din_valid = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
